// File: rtl/data_memory_line.sv
// Line-granular backing store for the data cache: 256-bit line reads/writes
// with a fixed multi-cycle access latency, emulating an off-chip DRAM.
module data_memory_line #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               wr_q,    wr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               ack_q,   ack_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               rst_sync_q;
    logic               mem_we_c;

    // Line storage; deliberately not cleared by reset.
    logic [LINE_W-1:0]  mem_q [DEPTH];

    // Offset bits and bits above the line index do not select anything.
    logic unused_addr_c;
    assign unused_addr_c = ^{addr_i[31:OFS_W+IDX_W], addr_i[OFS_W-1:0]};

    // Reset release is retimed so no request is accepted on the release edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, access on the WAIT->ACK edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        mem_we_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && rst_sync_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                    idx_d   = addr_i[OFS_W +: IDX_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (wr_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line write commit; gated by state so a reset during WAIT drops it.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_line.sv
// Directed bench for data_memory_line with a timing/data scoreboard.
module tb_data_memory_line;

    localparam int unsigned LAT = 10;
    localparam int unsigned DEP = 512;

    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i  = 1'b0;
    logic [31:0]  addr_i   = '0;
    logic [255:0] data_i   = '0;
    logic         ack_o;
    logic [255:0] data_o;

    data_memory_line #(.DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         is_rd;
        logic [255:0] data;
        int unsigned  cyc;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] model [DEP];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every ack must match the oldest expectation in cycle and (for reads) data.
    always @(negedge clk_i) begin
        if (ack_o === 1'b1) begin : mon
            exp_t e;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_ack observed=1 expected=0 cycle=%0d", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_cycle", 256'(cyc), 256'(e.cyc));
                if (e.is_rd) check("ack_read_data", data_o, e.data);
            end
        end
    end

    // Drive a request just after a falling edge; accepted on the next rising edge.
    task automatic start_req(input logic wr, input logic [31:0] addr,
                             input logic [255:0] d, input bit track);
        exp_t       e;
        logic [8:0] idx;
        idx      = addr[13:5];
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = d;
        if (track) begin
            e.is_rd = !wr;
            e.data  = model[idx];
            e.cyc   = cyc + 1 + LAT;
            sb.push_back(e);
            if (wr) model[idx] = d;
        end
    endtask

    task automatic wait_ack(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < int'(LAT) + 6; i++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [255:0] d, input string tag);
        @(negedge clk_i);
        start_req(wr, addr, d, 1'b1);
        wait_ack(tag);
        enable_i = 1'b0;
    endtask

    initial begin
        logic [255:0] c_wr;
        logic [255:0] w2;
        logic [255:0] newd;
        logic [255:0] d6;
        logic [255:0] d1;
        logic [255:0] pre5;
        int unsigned  t1;
        exp_t         e2;
        bit           seen;

        c_wr = {4{64'h0123_4567_89AB_CDEF}};
        w2   = {8{32'hCAFE_F00D}};
        newd = {8{32'hDEAD_BEEF}};
        d6   = {16{16'h6B6B}};

        for (int i = 0; i < int'(DEP); i++) begin
            model[i] = (i == 3) ? {32{8'hA5}} : {8{32'(i) ^ 32'h3C00_0000}};
            dut.mem_q[i] = model[i];
        end

        #1;
        check("reset_ack", 256'(ack_o), 256'(1'b0));
        check("reset_data", data_o, '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Read of preloaded line 3.
        do_req(1'b0, 32'h0000_0060, '0, "rd_line3");
        check("rd_line3_data", data_o, {32{8'hA5}});
        @(negedge clk_i);
        check("ack_one_cycle", 256'(ack_o), 256'(1'b0));

        // Asynchronous reset mid-cycle with a request pending on the inputs.
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h0000_0060;
        #1 rst_i = 1'b0;
        #1;
        check("async_rst_ack", 256'(ack_o), 256'(1'b0));
        check("async_rst_data", data_o, '0);
        repeat (3) begin
            @(negedge clk_i);
            check("rst_no_ack", 256'(ack_o), 256'(1'b0));
        end
        enable_i = 1'b0;
        rst_i    = 1'b1;
        repeat (2) @(negedge clk_i);

        // Write then read the same line; a write leaves data_o alone.
        do_req(1'b1, 32'h0000_1F80, c_wr, "wr_1f80");
        check("wr_keeps_data", data_o, '0);
        @(negedge clk_i);
        do_req(1'b0, 32'h0000_1F80, '0, "rd_1f80");
        check("rd_1f80_data", data_o, c_wr);

        // Offset bits and high bits are ignored: 0x4045 and 0x40 hit line 2.
        do_req(1'b1, 32'h0000_4045, w2, "wr_wrap");
        do_req(1'b0, 32'h0000_0040, '0, "rd_wrap");
        check("rd_wrap_data", data_o, w2);

        // Reset during WAIT drops an uncommitted write.
        pre5 = model[5];
        @(negedge clk_i);
        start_req(1'b1, 32'h0000_00A0, newd, 1'b0);
        repeat (6) @(negedge clk_i);
        #1 rst_i = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        do_req(1'b0, 32'h0000_00A0, '0, "rd_after_abort");
        check("abort_keeps_line", data_o, pre5);

        // Reset during ACK keeps a write committed on the WAIT->ACK edge.
        @(negedge clk_i);
        start_req(1'b1, 32'h0000_00C0, d6, 1'b1);
        wait_ack("wr_commit");
        #1 rst_i = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        do_req(1'b0, 32'h0000_00C0, '0, "rd_committed");
        check("committed_line", data_o, d6);

        // Back-to-back with enable held: the second request is accepted at the
        // end of the IDLE cycle after ACK, so acks are LAT+2 cycles apart.
        d1 = model[1];
        @(negedge clk_i);
        t1 = cyc + 1 + LAT;
        start_req(1'b0, 32'h0000_0020, '0, 1'b1);
        e2.is_rd = 1'b1;
        e2.data  = model[2];
        e2.cyc   = t1 + LAT + 2;
        sb.push_back(e2);
        wait_ack("b2b_first");
        addr_i = 32'h0000_0040;
        seen   = 1'b0;
        for (int i = 0; i < int'(LAT) + 6; i++) begin
            @(negedge clk_i);
            if (ack_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("b2b_hold", data_o, d1);
        end
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL b2b_second_timeout observed=no_ack expected=ack");
        end
        enable_i = 1'b0;
        check("b2b_second_data", data_o, e2.data);

        repeat (3) @(negedge clk_i);
        check("sb_empty", 256'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
